// File: rtl/seq_shift_add_mul_pkg.sv
// Shared types for the sequential shift-add multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/seq_shift_add_mul_if.sv
// Start/done handshake and operand/result bus of the multiplier.
interface seq_shift_add_mul_if #(
  parameter int unsigned WIDTH = 16
);
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/seq_shift_add_mul_pp_gate.sv
// Width-generic partial-product gate: every multiplicand bit ANDed with one multiplier bit.
module pp_gate #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic             b,
  output logic [WIDTH-1:0] y
);

  always_comb y = a & {WIDTH{b}};

endmodule

// File: rtl/seq_shift_add_mul.sv
// Multi-cycle unsigned shift-add multiplier, one partial product per clock.
// Optional ZERO_BYPASS_EN: zero operands skip the iterations and finish in one cycle.
module seq_shift_add_mul
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input logic               clk,
  input logic               reset,
  seq_shift_add_mul_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  mul_state_t           state;
  logic [WIDTH-1:0]     a_q;
  // Accumulator kept at 2W bits: the extra carry bit of the shift register is always zero.
  logic [2*WIDTH-1:0]   p_q;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   product_q;
  logic                 busy_q;
  logic                 done_q;

  logic [WIDTH-1:0]     pp;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   p_next;

  pp_gate #(.WIDTH(WIDTH)) u_pp_gate (
    .a (a_q),
    .b (p_q[0]),
    .y (pp)
  );

  always_comb begin
    sum    = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, pp};
    p_next = {sum, p_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      a_q       <= '0;
      p_q       <= '0;
      cnt       <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            a_q    <= bus.a;
            p_q    <= {{WIDTH{1'b0}}, bus.b};
            cnt    <= '0;
            busy_q <= 1'b1;
`ifdef ZERO_BYPASS_EN
            if (bus.a == '0 || bus.b == '0) begin
              state     <= S_DONE;
              product_q <= '0;
              done_q    <= 1'b1;
            end else begin
              state <= S_RUN;
            end
`else
            state <= S_RUN;
`endif
          end
        end
        S_RUN: begin
          p_q <= p_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            product_q <= p_next;
            state     <= S_DONE;
            done_q    <= 1'b1;
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule

// File: tb/tb_seq_shift_add_mul.sv
// Directed bench for seq_shift_add_mul at WIDTH=16 and WIDTH=8.
module tb_seq_shift_add_mul;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_shift_add_mul_if #(.WIDTH(16)) bus16 ();
  seq_shift_add_mul_if #(.WIDTH(8))  bus8 ();

  seq_shift_add_mul #(.WIDTH(16)) u_dut16 (.clk(clk), .reset(reset), .bus(bus16));
  seq_shift_add_mul #(.WIDTH(8))  u_dut8  (.clk(clk), .reset(reset), .bus(bus8));

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // k counts edges after the accept edge at which each sample is taken.
  task automatic run16(input logic [15:0] a, input logic [15:0] b,
                       output logic [31:0] p, output int lat, output int busy_cnt);
    bus16.start = 1'b1;
    bus16.a     = a;
    bus16.b     = b;
    step();
    bus16.start = 1'b0;
    lat      = -1;
    busy_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus16.busy) busy_cnt++;
      if (bus16.done && lat < 0) lat = k;
      if (!bus16.busy) break;
      step();
    end
    p = bus16.product;
  endtask

  logic [31:0] p;
  int          lat, bc, k;
  logic [63:0] exp_p;

  initial begin
    reset = 1'b1;
    bus16.start = 1'b0; bus16.a = '0; bus16.b = '0;
    bus8.start  = 1'b0; bus8.a  = '0; bus8.b  = '0;
    repeat (3) step();
    check("rst_busy16", bus16.busy, 0);
    check("rst_done16", bus16.done, 0);
    check("rst_prod16", bus16.product, 0);
    check("rst_prod8", bus8.product, 0);
    reset = 1'b0;
    step();

    // basic timing
    run16(16'd3, 16'd5, p, lat, bc);
    check("t1_prod", p, 64'h0000_000F);
    check("t1_lat", lat, 16);
    check("t1_busy", bc, 17);

    // carry / MSB paths
    run16(16'hFFFF, 16'hFFFF, p, lat, bc);
    check("t2_ffff", p, 64'hFFFE_0001);
    run16(16'h8000, 16'h8000, p, lat, bc);
    check("t2_8000", p, 64'h4000_0000);

    // starts while busy are dropped
    bus16.start = 1'b1; bus16.a = 16'h0012; bus16.b = 16'h0034;
    step();
    bus16.start = 1'b0;
    repeat (4) step();
    bus16.start = 1'b1; bus16.a = 16'hFFFF; bus16.b = 16'hFFFF;
    step();
    bus16.start = 1'b0;
    check("t3_run_busy", bus16.busy, 1);
    check("t3_prod_hold", bus16.product, 64'h4000_0000);
    k = 5;
    while (!bus16.done && k < 40) begin step(); k++; end
    check("t3_lat", k, 16);
    check("t3_prod", bus16.product, 64'h0000_03A8);
    bus16.start = 1'b1;
    step();
    bus16.start = 1'b0;
    check("t3_done_ignored", bus16.busy, 0);
    step();
    check("t3_idle", bus16.busy, 0);
    check("t3_prod_keep", bus16.product, 64'h0000_03A8);

    // async reset mid-operation
    bus16.start = 1'b1; bus16.a = 16'h1111; bus16.b = 16'h2222;
    step();
    bus16.start = 1'b0;
    repeat (7) step();
    reset = 1'b1;
    #1;
    check("t4_busy", bus16.busy, 0);
    check("t4_done", bus16.done, 0);
    check("t4_prod", bus16.product, 0);
    repeat (20) begin
      step();
      if (bus16.done) check("t4_no_done", bus16.done, 0);
    end
    reset = 1'b0;
    step();
    run16(16'h1234, 16'h0010, p, lat, bc);
    check("t4_after", p, 64'h0001_2340);

    // zero operand
    run16(16'h0000, 16'hABCD, p, lat, bc);
    check("t5_prod", p, 0);
`ifdef ZERO_BYPASS_EN
    check("t5_lat", lat, 0);
`else
    check("t5_lat", lat, 16);
`endif

    // start held high, WIDTH=8: accepted one edge after each return to IDLE
    bus8.a = 8'($urandom); bus8.b = 8'($urandom);
    exp_p = 64'(bus8.a) * 64'(bus8.b);
    bus8.start = 1'b1;
    for (int op = 0; op < 1000; op++) begin
      k = 0;
      do begin step(); k++; end while (!bus8.done && k < 40);
      check("t6_w8_done", bus8.done, 1);
      check("t6_w8_prod", bus8.product, exp_p);
      if (op > 0 && exp_p != 0 && bus8.a != 0) check("t6_w8_gap", k, 10);
      bus8.a = 8'($urandom); bus8.b = 8'($urandom);
      if (op % 97 == 0) bus8.b = '0;
      exp_p = 64'(bus8.a) * 64'(bus8.b);
    end
    bus8.start = 1'b0;
    repeat (12) step();

    // start held high, WIDTH=16
    bus16.a = 16'($urandom); bus16.b = 16'($urandom);
    exp_p = 64'(bus16.a) * 64'(bus16.b);
    bus16.start = 1'b1;
    for (int op = 0; op < 1000; op++) begin
      k = 0;
      do begin step(); k++; end while (!bus16.done && k < 40);
      check("t6_w16_done", bus16.done, 1);
      check("t6_w16_prod", bus16.product, exp_p);
      if (op > 0) check("t6_w16_gap", k, 18);
      bus16.a = 16'($urandom); bus16.b = 16'($urandom | 1);
      if (bus16.a == 0) bus16.a = 16'h0001;
      exp_p = 64'(bus16.a) * 64'(bus16.b);
    end
    bus16.start = 1'b0;
    repeat (20) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
